avalon_stall_bridge: RTL and testbench

- Sits on the Avalon memory-mapped bus between the mips_cpu_bus master (upstream) and the RAM slave (downstream).
- Latches each CPU transaction and inserts a configurable number of stall cycles, fixed or pseudo-random, on cpu_waitrequest.
- Then forwards the transaction to memory and returns the memory response to the CPU.
- Purpose: exercise the CPU's waitrequest handling under controlled, repeatable bus latency.

---
 rtl/avalon_bridge_pkg.sv | 26 ++
 rtl/lfsr16.sv | 25 ++
 rtl/avalon_stall_bridge.sv | 151 +++++++++++++++
 tb/tb_avalon_stall_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Avalon stall-injection bridge.
package avalon_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    FORWARD,
    RESPOND
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  localparam int unsigned WAIT_W    = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [WAIT_W-1:0] clamp_wait(
    input logic [WAIT_W-1:0] raw,
    input logic [WAIT_W-1:0] lim
  );
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), feedback into bit 0.
module lfsr16
  import avalon_bridge_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/avalon_stall_bridge.sv
// Avalon-MM bridge between CPU master and RAM slave that latches each request,
// stalls it for a fixed or LFSR-drawn number of cycles, then forwards it.
module avalon_stall_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int unsigned RANDOM_WAIT = 0,
  parameter int unsigned FIXED_WAIT  = 0,
  parameter int unsigned MAX_WAIT    = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic [15:0] txn_count
);

  localparam logic [WAIT_W-1:0] FIXED_W = FIXED_WAIT[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] MAX_W   = MAX_WAIT[WAIT_W-1:0];

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       txn_q, txn_d;

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_unused;
  logic [WAIT_W-1:0] n_wait;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .state_o (lfsr)
  );

  // Only the low nibble feeds the stall count; the rest just keeps the sequence long.
  assign lfsr_unused = lfsr;

  always_comb begin
    if (RANDOM_WAIT != 0) n_wait = clamp_wait(lfsr[WAIT_W-1:0], MAX_W);
    else                  n_wait = FIXED_W;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    txn_d    = txn_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          addr_d  = cpu_address;
          wdata_d = cpu_writedata;
          be_d    = cpu_byteenable;
          op_d    = cpu_write ? OP_WRITE : OP_READ;
          cnt_d   = n_wait;
          if (n_wait != '0) begin
            state_d = STALL;
          end else begin
            // Strobes are registered, so they must be set on the edge entering FORWARD.
            state_d  = FORWARD;
            mem_rd_d = !cpu_write;
            mem_wr_d = cpu_write;
          end
        end
      end
      STALL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) begin
          state_d  = FORWARD;
          mem_rd_d = (op_q == OP_READ);
          mem_wr_d = (op_q == OP_WRITE);
        end
      end
      FORWARD: begin
        if (!mem_waitrequest) begin
          if (op_q == OP_READ) rdata_d = mem_readdata;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        if (txn_q != '1) txn_d = txn_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_READ;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      txn_q    <= txn_d;
    end
  end

  assign cpu_waitrequest = (state_q != RESPOND);
  assign cpu_readdata    = rdata_q;
  assign mem_address     = addr_q;
  assign mem_read        = mem_rd_q;
  assign mem_write       = mem_wr_q;
  assign mem_writedata   = wdata_q;
  assign mem_byteenable  = be_q;
  assign txn_count       = txn_q;

endmodule

// File: tb/tb_avalon_stall_bridge.sv
// Scoreboard bench: instance 0 uses a fixed 3-cycle stall, instance 1 LFSR stalls clamped to 5.
module tb_avalon_stall_bridge;

  localparam int unsigned NI   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cpu_address     [NI];
  logic        cpu_read        [NI];
  logic        cpu_write       [NI];
  logic [31:0] cpu_writedata   [NI];
  logic [3:0]  cpu_byteenable  [NI];
  logic [31:0] cpu_readdata    [NI];
  logic        cpu_waitrequest [NI];
  logic [31:0] mem_address     [NI];
  logic        mem_read        [NI];
  logic        mem_write       [NI];
  logic [31:0] mem_writedata   [NI];
  logic [3:0]  mem_byteenable  [NI];
  logic [31:0] mem_readdata    [NI];
  logic        mem_waitrequest [NI];
  logic [15:0] txn_count       [NI];

  avalon_stall_bridge #(
    .RANDOM_WAIT(0), .FIXED_WAIT(3), .MAX_WAIT(7), .LFSR_SEED(SEED)
  ) u_fix (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address[0]), .cpu_read(cpu_read[0]), .cpu_write(cpu_write[0]),
    .cpu_writedata(cpu_writedata[0]), .cpu_byteenable(cpu_byteenable[0]),
    .cpu_readdata(cpu_readdata[0]), .cpu_waitrequest(cpu_waitrequest[0]),
    .mem_address(mem_address[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_writedata(mem_writedata[0]), .mem_byteenable(mem_byteenable[0]),
    .mem_readdata(mem_readdata[0]), .mem_waitrequest(mem_waitrequest[0]),
    .txn_count(txn_count[0])
  );

  avalon_stall_bridge #(
    .RANDOM_WAIT(1), .FIXED_WAIT(0), .MAX_WAIT(5), .LFSR_SEED(SEED)
  ) u_rnd (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address[1]), .cpu_read(cpu_read[1]), .cpu_write(cpu_write[1]),
    .cpu_writedata(cpu_writedata[1]), .cpu_byteenable(cpu_byteenable[1]),
    .cpu_readdata(cpu_readdata[1]), .cpu_waitrequest(cpu_waitrequest[1]),
    .mem_address(mem_address[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_writedata(mem_writedata[1]), .mem_byteenable(mem_byteenable[1]),
    .mem_readdata(mem_readdata[1]), .mem_waitrequest(mem_waitrequest[1]),
    .txn_count(txn_count[1])
  );

  function automatic logic [31:0] init_word(input int unsigned g, input int unsigned i);
    if (i == 0) return 32'h12345678;
    return 32'h11223344 ^ (i * 32'h01010101) ^ g;
  endfunction

  // RAM models: programmable wait states per access, byte-lane writes.
  logic [31:0] ram      [NI][64];
  int unsigned ram_wait [NI];
  int unsigned wcnt     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_ram
    assign mem_waitrequest[g] = (mem_read[g] | mem_write[g]) && (wcnt[g] < ram_wait[g]);
    assign mem_readdata[g]    = ram[g][mem_address[g][7:2]];
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ram_init)
        for (int i = 0; i < 64; i++) ram[g][i] <= init_word(g, i);
      if (reset) begin
        wcnt[g] <= 0;
      end else if (mem_read[g] | mem_write[g]) begin
        if (!mem_waitrequest[g]) begin
          wcnt[g] <= 0;
          if (mem_write[g])
            for (int b = 0; b < 4; b++)
              if (mem_byteenable[g][b])
                ram[g][mem_address[g][7:2]][8*b +: 8] <= mem_writedata[g][8*b +: 8];
        end else begin
          wcnt[g] <= wcnt[g] + 1;
        end
      end
    end
  end

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting left with feedback into bit 0.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int unsigned n;
    int unsigned w;
  } txn_t;

  txn_t        sb [$];
  logic [31:0] ref_mem   [NI][64];
  logic [31:0] exp_rdata [NI];
  logic [15:0] exp_cnt   [NI];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input int unsigned g, input int unsigned cycles);
    cpu_read[g]  = 1'b0;
    cpu_write[g] = 1'b0;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk("idle_wait", 32'(cpu_waitrequest[g]), 32'd1);
      chk("idle_strobe", 32'({mem_read[g], mem_write[g]}), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic do_txn(input int unsigned g, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int unsigned w);
    txn_t        t;
    txn_t        e;
    int unsigned idx;
    int unsigned raw;
    bit          done;
    idx = 32'(addr[7:2]);
    raw = 32'(lfsr_m[3:0]);
    ram_wait[g]       = w;
    cpu_address[g]    = addr;
    cpu_writedata[g]  = wdata;
    cpu_byteenable[g] = be;
    cpu_read[g]       = rd;
    cpu_write[g]      = wr;
    t.is_wr = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.be    = be;
    t.w     = w;
    t.n     = (g == 0) ? 3 : ((raw > 5) ? 5 : raw);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[g][idx][8*b +: 8] = wdata[8*b +: 8];
      t.rdata = exp_rdata[g];
    end else begin
      t.rdata = ref_mem[g][idx];
    end
    sb.push_back(t);
    done = 0;
    for (int unsigned k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (cpu_waitrequest[g] == 1'b0) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", k, 2 + e.n + e.w);
          chk("rdata", cpu_readdata[g], e.rdata);
          exp_rdata[g] = e.rdata;
        end
        done = 1;
      end else if (k >= 1 + t.n && k <= 1 + t.n + t.w) begin
        chk("mem_read", 32'(mem_read[g]), 32'(!t.is_wr));
        chk("mem_write", 32'(mem_write[g]), 32'(t.is_wr));
        chk("mem_addr", mem_address[g], t.addr);
        chk("mem_wdata", mem_writedata[g], t.wdata);
        chk("mem_be", 32'(mem_byteenable[g]), 32'(t.be));
      end else begin
        chk("strobe_low", 32'({mem_read[g], mem_write[g]}), 32'd0);
      end
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge clk);
    #1;
    if (exp_cnt[g] != 16'hFFFF) exp_cnt[g] = exp_cnt[g] + 16'd1;
    chk("txn_count", 32'(txn_count[g]), 32'(exp_cnt[g]));
  endtask

  initial begin
    bit found;
    for (int g = 0; g < NI; g++) begin
      cpu_address[g] = '0; cpu_read[g] = 1'b0; cpu_write[g] = 1'b0;
      cpu_writedata[g] = '0; cpu_byteenable[g] = '0;
      ram_wait[g] = 0; exp_rdata[g] = '0; exp_cnt[g] = '0;
      for (int i = 0; i < 64; i++) ref_mem[g][i] = init_word(g, i);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ram_init = 1'b0;

    for (int g = 0; g < NI; g++) begin
      chk("rst_wait", 32'(cpu_waitrequest[g]), 32'd1);
      chk("rst_strobe", 32'({mem_read[g], mem_write[g]}), 32'd0);
      chk("rst_addr", mem_address[g], 32'd0);
      chk("rst_wdata", mem_writedata[g], 32'd0);
      chk("rst_be", 32'(mem_byteenable[g]), 32'd0);
      chk("rst_rdata", cpu_readdata[g], 32'd0);
      chk("rst_cnt", 32'(txn_count[g]), 32'd0);
    end
    idle_chk(0, 3);

    do_txn(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 0);
    do_txn(0, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'b0011, 0);
    do_txn(0, 1'b1, 1'b0, 32'h00001000, 32'h0, 4'hF, 0);
    do_txn(0, 1'b1, 1'b1, 32'h00000040, 32'hCAFEF00D, 4'hF, 1);
    do_txn(0, 1'b1, 1'b0, 32'h00000040, 32'h0, 4'hF, 2);
    idle_chk(0, 2);

    do_txn(1, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 0);
    do_txn(1, 1'b1, 1'b0, 32'h00000020, 32'h0, 4'hF, 4);
    for (int i = 0; i < 40; i++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      do_txn(1, !wr, wr, $urandom, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
    idle_chk(1, 2);

    // Reset while a read is parked in FORWARD behind a long RAM stall.
    ram_wait[1] = 30;
    cpu_address[1] = 32'h00000080;
    cpu_read[1] = 1'b1;
    cpu_write[1] = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (mem_read[1]) found = 1;
    end
    chk("fwd_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_read[1] = 1'b0;
    ram_wait[1] = 0;
    chk("mrst_read", 32'(mem_read[1]), 32'd0);
    chk("mrst_wait", 32'(cpu_waitrequest[1]), 32'd1);
    chk("mrst_cnt", 32'(txn_count[1]), 32'd0);
    chk("mrst_rdata", cpu_readdata[1], 32'd0);
    for (int g = 0; g < NI; g++) begin
      exp_cnt[g] = '0;
      exp_rdata[g] = '0;
    end
    idle_chk(1, 1);

    for (int i = 0; i < 200; i++)
      do_txn(1, 1'b1, 1'b0, $urandom, 32'h0, 4'hF, $urandom_range(0, 3));
    chk("txn_total", 32'(txn_count[1]), 32'd200);
    chk("fix_cnt_kept", 32'(txn_count[0]), 32'd0);
    idle_chk(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
